// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and the memory (slave).
// Valid/ready semantics: imem_req is held with a stable imem_addr until the memory returns imem_ack with imem_rdata in the same cycle.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-issue fetch unit: requests one instruction, offers it downstream, then steps the PC by +4 or a branch offset.
// A misaligned target parks the unit in a sticky fault state that only reset clears.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master imem,
    input  logic         PCSrc,
    input  logic [31:0]  ImmOp,
    input  logic         stall,
    output logic [31:0]  PC,
    output logic [31:0]  instr,
    output logic         instr_valid,
    output logic [6:0]   op,
    output logic [2:0]   funct3,
    output logic         funct7_5,
    output logic [4:0]   rs1,
    output logic [4:0]   rs2,
    output logic [4:0]   rd,
    output logic         fault,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_ISSUE = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic [31:0] target;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        target  = PCSrc ? (pc_q + ImmOp) : (pc_q + 32'd4);

        case (state_q)
            S_REQ: begin
                // Ack outside this state is dropped, so instr only loads here.
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    if (target[1:0] == 2'b00) begin
                        pc_d    = target;
                        state_d = S_REQ;
                    end else begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Handshake outputs are forced low while rst is high, before the first reset edge lands.
    assign imem.imem_req  = (state_q == S_REQ) && !rst;
    assign imem.imem_addr = pc_q;
    assign instr_valid    = (state_q == S_ISSUE) && !rst;
    assign fault          = fault_q;
    assign PC             = pc_q;
    assign instr          = instr_q;
    assign state_dbg      = state_q;

    assign op       = instr_q[6:0];
    assign funct3   = instr_q[14:12];
    assign funct7_5 = instr_q[30];
    assign rs1      = instr_q[19:15];
    assign rs2      = instr_q[24:20];
    assign rd       = instr_q[11:7];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized fetch/issue rounds against a PC-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        PCSrc;
    logic [31:0] ImmOp;
    logic        stall;
    logic [31:0] PC;
    logic [31:0] instr;
    logic        instr_valid;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        fault;
    logic [1:0]  state_dbg;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (bus),
        .PCSrc      (PCSrc),
        .ImmOp      (ImmOp),
        .stall      (stall),
        .PC         (PC),
        .instr      (instr),
        .instr_valid(instr_valid),
        .op         (op),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .fault      (fault),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the PC and instruction the unit should be holding.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_fault;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input string tag, input logic [31:0] word);
        logic [31:0] w;
        w = word;
        chk({tag, " instr"}, instr, w);
        chk({tag, " op"}, {25'd0, op}, {25'd0, w[6:0]});
        chk({tag, " funct3"}, {29'd0, funct3}, {29'd0, w[14:12]});
        chk({tag, " funct7_5"}, {31'd0, funct7_5}, {31'd0, w[30]});
        chk({tag, " rs1"}, {27'd0, rs1}, {27'd0, w[19:15]});
        chk({tag, " rs2"}, {27'd0, rs2}, {27'd0, w[24:20]});
        chk({tag, " rd"}, {27'd0, rd}, {27'd0, w[11:7]});
    endtask

    task automatic do_reset(input bit ack_during);
        rst   = 1'b1;
        stall = 1'($urandom_range(0, 1));
        PCSrc = 1'($urandom_range(0, 1));
        ImmOp = $urandom();
        bus.imem_ack   = ack_during;
        bus.imem_rdata = $urandom();
        step();
        step();
        chk("rst pc", PC, RESET_PC);
        chk("rst req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst valid", {31'd0, instr_valid}, 32'd0);
        chk("rst fault", {31'd0, fault}, 32'd0);
        check_fields("rst", 32'd0);
        rst          = 1'b0;
        bus.imem_ack = 1'b0;
        m_pc    = RESET_PC;
        m_instr = 32'd0;
        m_fault = 1'b0;
        step();
        chk("post-rst req", {31'd0, bus.imem_req}, 32'd1);
        chk("post-rst addr", bus.imem_addr, RESET_PC);
        chk("post-rst instr", instr, 32'd0);
    endtask

    // Entered at a negedge in the request phase; leaves at the first issue cycle.
    task automatic fetch(input int waits, input logic [31:0] word);
        for (int i = 0; i < waits; i++) begin
            chk("wait req", {31'd0, bus.imem_req}, 32'd1);
            chk("wait addr", bus.imem_addr, m_pc);
            chk("wait valid", {31'd0, instr_valid}, 32'd0);
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom();
            PCSrc = 1'($urandom_range(0, 1));
            ImmOp = $urandom();
            stall = 1'($urandom_range(0, 1));
            step();
        end
        chk("ack req", {31'd0, bus.imem_req}, 32'd1);
        chk("ack addr", bus.imem_addr, m_pc);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        PCSrc = 1'($urandom_range(0, 1));
        ImmOp = $urandom() | 32'd1;
        step();
        bus.imem_ack = 1'b0;
        m_instr = word;
        chk("issue valid", {31'd0, instr_valid}, 32'd1);
        chk("issue req", {31'd0, bus.imem_req}, 32'd0);
        chk("issue pc", PC, m_pc);
        check_fields("issue", word);
    endtask

    // Entered at the first issue cycle; holds for `stalls` cycles, then releases.
    task automatic issue(input int stalls, input logic src, input logic [31:0] imm);
        logic [31:0] tgt;
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            PCSrc = 1'(i & 1);
            ImmOp = $urandom();
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom();
            step();
            chk("stall valid", {31'd0, instr_valid}, 32'd1);
            chk("stall req", {31'd0, bus.imem_req}, 32'd0);
            chk("stall pc", PC, m_pc);
            chk("stall instr", instr, m_instr);
        end
        stall = 1'b0;
        bus.imem_ack = 1'b0;
        PCSrc = src;
        ImmOp = imm;
        step();
        tgt = src ? (m_pc + imm) : (m_pc + 32'd4);
        if (tgt[1:0] == 2'b00) begin
            m_pc = tgt;
            chk("next req", {31'd0, bus.imem_req}, 32'd1);
            chk("next addr", bus.imem_addr, m_pc);
            chk("next fault", {31'd0, fault}, 32'd0);
        end else begin
            m_fault = 1'b1;
            chk("fault flag", {31'd0, fault}, 32'd1);
            chk("fault req", {31'd0, bus.imem_req}, 32'd0);
            chk("fault pc", PC, m_pc);
        end
        chk("after valid", {31'd0, instr_valid}, 32'd0);
        PCSrc = 1'($urandom_range(0, 1));
        ImmOp = $urandom();
    endtask

    task automatic fault_hold(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom();
            PCSrc = 1'($urandom_range(0, 1));
            ImmOp = $urandom() & 32'hFFFF_FFFC;
            stall = 1'($urandom_range(0, 1));
            step();
            chk("hold fault", {31'd0, fault}, 32'd1);
            chk("hold req", {31'd0, bus.imem_req}, 32'd0);
            chk("hold valid", {31'd0, instr_valid}, 32'd0);
            chk("hold pc", PC, m_pc);
            chk("hold instr", instr, m_instr);
        end
        bus.imem_ack = 1'b0;
    endtask

    task automatic branch_to(input logic [31:0] dest);
        fetch(0, $urandom());
        issue(0, 1'b1, dest - m_pc);
    endtask

    initial begin
        logic [31:0] imm;
        rst = 1'b1;
        PCSrc = 1'b0;
        ImmOp = 32'd0;
        stall = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        m_pc = RESET_PC;
        m_instr = 32'd0;
        m_fault = 1'b0;
        step();
        do_reset(1'b0);

        // Three wait cycles, then decode of addi x1, x2, 5.
        fetch(3, 32'h0051_0093);
        chk("addi op", {25'd0, op}, 32'h13);
        chk("addi rd", {27'd0, rd}, 32'd1);
        chk("addi rs1", {27'd0, rs1}, 32'd2);
        chk("addi funct3", {29'd0, funct3}, 32'd0);
        issue(0, 1'b1, 32'h10);

        // Sequential step from 0x10 with zero-wait acks.
        fetch(0, $urandom());
        issue(0, 1'b0, $urandom());
        chk("seq addr", bus.imem_addr, 32'h14);
        fetch(0, $urandom());

        // Backward branch from 0x40.
        issue(0, 1'b1, 32'h40 - m_pc);
        fetch(0, $urandom());
        issue(0, 1'b1, 32'hFFFF_FFF0);
        chk("back addr", bus.imem_addr, 32'h30);

        // Long stall; release-cycle PCSrc decides.
        fetch(1, $urandom());
        issue(5, 1'b1, 32'h100);
        chk("stall target", bus.imem_addr, 32'h130);

        // PC wrap at the top of the address space.
        branch_to(32'hFFFF_FFFC);
        fetch(2, $urandom());
        issue(0, 1'b0, $urandom());
        chk("wrap addr", bus.imem_addr, 32'h0);

        // Misaligned branch target at 0x20.
        branch_to(32'h20);
        fetch(0, $urandom());
        issue(0, 1'b1, 32'h6);
        chk("mis pc", PC, 32'h20);
        fault_hold(4);
        do_reset(1'b0);

        // Reset while waiting on memory, with a late ack.
        fetch(0, $urandom());
        issue(0, 1'b0, 32'd0);
        bus.imem_ack = 1'b0;
        step();
        do_reset(1'b1);

        // Reset during a stalled issue.
        fetch(1, $urandom());
        stall = 1'b1;
        step();
        do_reset(1'b1);

        for (int r = 0; r < 40; r++) begin
            fetch($urandom_range(0, 3), $urandom());
            imm = $urandom() & 32'h0000_0FFC;
            if ($urandom_range(0, 7) == 0) imm = imm | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) imm = -imm;
            issue($urandom_range(0, 3), 1'($urandom_range(0, 1)), imm);
            if (m_fault) begin
                fault_hold(2);
                do_reset(1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
